uart_tx_frame: RTL

Parametrised UART transmitter: successor to the fixed 8-bit, external-baud-clock transmitter in the UART block. It generates its own bit timing from a programmable divisor and supports runtime-selectable 5–8 data bits, none/even/odd parity, and 1 or 2 stop bits. A valid/ready write port feeds it through an optional transmit FIFO. It sits between the register/bus interface (which owns all configuration fields) and the `txd` pad.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_sync_fifo.sv | 48 ++++
 rtl/uart_tx_frame.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, frame configuration payload and parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic [1:0] DB_5 = 2'b00;
  localparam logic [1:0] DB_6 = 2'b01;
  localparam logic [1:0] DB_7 = 2'b10;
  localparam logic [1:0] DB_8 = 2'b11;

  typedef struct packed {
    logic [1:0] data_bits;
    logic       parity_en;
    logic       parity_odd;
    logic       stop2;
  } uart_frame_cfg_t;

  // Parity over the low (len+5) bits only; odd parity is the inverted XOR.
  function automatic logic parity_calc(input logic [7:0] data, input logic [1:0] len,
                                       input logic odd);
    logic [7:0] mask;
    mask = 8'hFF >> (2'd3 - len);
    return (^(data & mask)) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two, >= 2.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = level[AW];
  assign empty    = (level == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage array carries no reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter with programmable divisor and 5-8N/E/O 1-2 frame format.
// Define UART_TX_FIFO_EN to queue writes in a FIFO instead of a single holding register.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_en,
  input  logic [DIV_W-1:0]              div,
  input  logic [1:0]                    data_bits,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic                          stop2,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          txd
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  uart_state_e     state;
  uart_state_e     state_nxt;
  uart_frame_cfg_t cfg_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      sh;
  logic            par_q;

  logic            push_c;
  logic            pop_c;
  logic            done_c;
  logic            bit_end_c;
  logic [2:0]      last_data_c;
  logic            q_avail;
  logic [7:0]      q_data;

  assign push_c      = wr_valid & wr_ready;
  assign bit_end_c   = (cnt == '0);
  assign last_data_c = 3'(cfg_q.data_bits) + 3'd4;

`ifdef UART_TX_FIFO_EN
  logic fifo_full;
  logic fifo_empty;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_c),
    .push_data (wr_data),
    .pop       (pop_c),
    .pop_data  (q_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign wr_ready = ~fifo_full;
  assign q_avail  = ~fifo_empty;
`else
  logic       hold_valid;
  logic [7:0] hold_data;

  // Holding register is freed as soon as its byte is loaded into the shifter
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (push_c) begin
      hold_valid <= 1'b1;
      hold_data  <= wr_data;
    end else if (pop_c) begin
      hold_valid <= 1'b0;
    end
  end

  assign wr_ready = ~hold_valid;
  assign q_avail  = hold_valid;
  assign q_data   = hold_data;
  assign level    = LVL_W'(hold_valid);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state; pop_c marks entry to START, done_c the final stop-bit cycle
  always_comb begin
    state_nxt = state;
    pop_c     = 1'b0;
    done_c    = 1'b0;
    if (!tx_en) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (q_avail) begin
            state_nxt = ST_START;
            pop_c     = 1'b1;
          end
        end
        ST_START: begin
          if (bit_end_c) state_nxt = ST_DATA;
        end
        ST_DATA: begin
          if (bit_end_c && (bit_idx == last_data_c))
            state_nxt = cfg_q.parity_en ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: begin
          if (bit_end_c) state_nxt = ST_STOP;
        end
        ST_STOP: begin
          if (bit_end_c && (bit_idx == 3'(cfg_q.stop2))) begin
            done_c = 1'b1;
            if (q_avail) begin
              state_nxt = ST_START;
              pop_c     = 1'b1;
            end else begin
              state_nxt = ST_IDLE;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Bit timing, shifter and per-frame configuration shadow
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q   <= '0;
      div_q   <= '0;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      par_q   <= 1'b0;
    end else if (pop_c) begin
      cfg_q.data_bits  <= data_bits;
      cfg_q.parity_en  <= parity_en;
      cfg_q.parity_odd <= parity_odd;
      cfg_q.stop2      <= stop2;
      div_q            <= div;
      cnt              <= div;
      bit_idx          <= '0;
      sh               <= q_data;
      par_q            <= parity_calc(q_data, data_bits, parity_odd);
    end else if (state != ST_IDLE) begin
      if (bit_end_c) begin
        cnt     <= div_q;
        bit_idx <= (state_nxt == state) ? bit_idx + 3'd1 : 3'd0;
        if (state == ST_DATA) sh <= sh >> 1;
      end else begin
        cnt <= cnt - DIV_W'(1);
      end
    end
  end

  // Line and status registers follow the FSM by one cycle, keeping all bits equal length
  always_ff @(posedge clk) begin
    if (rst) begin
      txd     <= 1'b1;
      tx_done <= 1'b0;
      busy    <= 1'b0;
    end else begin
      tx_done <= done_c;
      busy    <= (state != ST_IDLE) | q_avail;
      if (!tx_en) begin
        txd <= 1'b1;
      end else begin
        case (state)
          ST_START:  txd <= 1'b0;
          ST_DATA:   txd <= sh[0];
          ST_PARITY: txd <= par_q;
          default:   txd <= 1'b1;
        endcase
      end
    end
  end

endmodule
